// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the fetch/load-store memory bus arbiter
package mem_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int BEW  = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic            we;
        logic [BEW-1:0]  be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - data-first grant decision with a fetch starvation override
module mem_arb_sel
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_req,
    input  logic             ls_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output bus_state_e       grant
);

    always_comb begin
        grant = IDLE;
        if (ls_req && (!if_req || (starve_cnt < CNT_W'(STARVE_MAX)))) begin
            grant = GNT_D;
        end else if (if_req) begin
            grant = GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory bus between instruction fetch and load/store
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_ack,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [BEW-1:0]  ls_be,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [BEW-1:0]  mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            busy_F,
    output logic            busy_M
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    bus_state_e       state_q;
    bus_state_e       grant;
    mem_req_t         lat_q;
    mem_req_t         fetch_req;
    mem_req_t         data_req;
    logic             mem_req_q;
    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    // Fetches are always full-word reads.
    assign fetch_req = '{we: 1'b0, be: {BEW{1'b1}}, addr: if_addr, wdata: {XLEN{1'b0}}};
    assign data_req  = '{we: ls_we, be: ls_be, addr: ls_addr, wdata: ls_wdata};

    mem_arb_sel #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_sel (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .starve_cnt (starve_q),
        .grant      (grant)
    );

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (grant == GNT_I) begin
                starve_d = '0;
            end else if (grant == GNT_D && if_req && starve_q < CNT_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            lat_q     <= '0;
            starve_q  <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                IDLE: begin
                    case (grant)
                        GNT_D: begin
                            state_q   <= GNT_D;
                            mem_req_q <= 1'b1;
                            lat_q     <= data_req;
                        end
                        GNT_I: begin
                            state_q   <= GNT_I;
                            mem_req_q <= 1'b1;
                            lat_q     <= fetch_req;
                        end
                        default: ;
                    endcase
                end
                GNT_I, GNT_D: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = lat_q.we;
    assign mem_be    = lat_q.be;
    assign mem_addr  = lat_q.addr;
    assign mem_wdata = lat_q.wdata;

    // Acks are tied to the owning state, so a stray mem_ack in IDLE produces nothing.
    assign if_ack   = mem_ack && (state_q == GNT_I);
    assign ls_ack   = mem_ack && (state_q == GNT_D);
    assign if_rdata = mem_rdata;
    assign ls_rdata = mem_rdata;

    assign busy_F = if_req & ~if_ack;
    assign busy_M = ls_req & ~ls_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    typedef struct {
        bit          is_data;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy_F;
    logic        busy_M;

    int   checks;
    int   failures;
    exp_t exp_q[$];

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_rdata  (ls_rdata),
        .ls_ack    (ls_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy_F    (busy_F),
        .busy_M    (busy_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit is_data, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.is_data = is_data;
        e.we      = we;
        e.be      = be;
        e.addr    = addr;
        e.wdata   = wdata;
        exp_q.push_back(e);
    endtask

    // Memory side: wait for the next bus request, compare it with the scoreboard head,
    // hold it for `delay` extra cycles, then complete it with random read data.
    task automatic serve(input int delay);
        int          cyc;
        exp_t        e;
        logic [31:0] rd;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (mem_req !== 1'b1 && cyc < 20);
        chk("req_seen", {31'd0, mem_req}, 32'd1);
        if (mem_req !== 1'b1) return;
        chk("req_latency", cyc, 32'd1);
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL sb_pop observed=empty expected=entry");
            return;
        end
        e = exp_q.pop_front();
        chk("bus_we", {31'd0, mem_we}, {31'd0, e.we});
        chk("bus_be", {28'd0, mem_be}, {28'd0, e.be});
        chk("bus_addr", mem_addr, e.addr);
        chk("bus_wdata", mem_wdata, e.wdata);
        chk("no_early_ack", {30'd0, if_ack, ls_ack}, 32'd0);
        chk("owner_busy", {31'd0, e.is_data ? busy_M : busy_F}, 32'd1);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk);
            #1;
            chk("hold_req", {31'd0, mem_req}, 32'd1);
            chk("hold_addr", mem_addr, e.addr);
        end
        rd = $urandom;
        mem_rdata = rd;
        mem_ack = 1'b1;
        #1;
        chk("if_ack", {31'd0, if_ack}, {31'd0, !e.is_data});
        chk("ls_ack", {31'd0, ls_ack}, {31'd0, e.is_data});
        chk("owner_rdata", e.is_data ? ls_rdata : if_rdata, rd);
        chk("owner_busy_at_ack", {31'd0, e.is_data ? busy_M : busy_F}, 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("req_drop", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        int d;
        int f;
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_be     = '0;
        ls_addr   = '0;
        ls_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch only, ack on the third bus cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        push_exp(1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        serve(2);
        if_req = 1'b0;

        // Store only
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_be    = 4'b0011;
        ls_addr  = 32'h0000_2004;
        ls_wdata = 32'hDEAD_BEEF;
        push_exp(1'b1, 1'b1, 4'b0011, 32'h0000_2004, 32'hDEAD_BEEF);
        serve(1);
        ls_req = 1'b0;

        // Simultaneous requests: data wins first, then fetch
        ls_we    = 1'b0;
        ls_be    = 4'hF;
        ls_addr  = 32'h0000_3000;
        ls_wdata = 32'h1111_1111;
        if_addr  = 32'h0000_0400;
        ls_req   = 1'b1;
        if_req   = 1'b1;
        push_exp(1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h1111_1111);
        push_exp(1'b0, 1'b0, 4'hF, 32'h0000_0400, 32'h0);
        serve(0);
        ls_req = 1'b0;
        serve(1);
        if_req = 1'b0;

        // Both held: four data grants, one fetch, and again after the counter clears
        d       = 0;
        f       = 0;
        ls_addr = 32'h0000_5000;
        if_addr = 32'h0000_0800;
        ls_req  = 1'b1;
        if_req  = 1'b1;
        for (int g = 0; g < 10; g++) begin
            if ((g % 5) == 4) begin
                push_exp(1'b0, 1'b0, 4'hF, if_addr, 32'h0);
                serve(0);
                f++;
                if_addr = 32'h0000_0800 + 32'(f * 4);
            end else begin
                push_exp(1'b1, 1'b0, 4'hF, ls_addr, 32'h1111_1111);
                serve(0);
                d++;
                ls_addr = 32'h0000_5000 + 32'(d * 4);
            end
        end
        ls_req = 1'b0;
        if_req = 1'b0;
        chk("sb_drained", exp_q.size(), 32'd0);

        // Mid-transfer address change, then asynchronous reset
        ls_addr = 32'h0000_6000;
        ls_req  = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_req", {31'd0, mem_req}, 32'd1);
        chk("t5_addr", mem_addr, 32'h0000_6000);
        ls_addr = 32'h0000_6FF0;
        @(posedge clk);
        #1;
        chk("t5_addr_held", mem_addr, 32'h0000_6000);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_req", {31'd0, mem_req}, 32'd0);
        chk("t5_async_addr", mem_addr, 32'd0);
        ls_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Stray mem_ack in IDLE must not produce an ack or a request
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("idle_ack_ignored", {30'd0, if_ack, ls_ack}, 32'd0);
            chk("idle_no_req", {31'd0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;

        // Normal operation after reset
        if_addr = 32'h0000_0A00;
        if_req  = 1'b1;
        push_exp(1'b0, 1'b0, 4'hF, 32'h0000_0A00, 32'h0);
        serve(0);
        if_req = 1'b0;

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
